// File: rtl/display_sink_module.sv
// Hex display sink: captures a 16-bit producer result and streams it as four
// ASCII hex digits (MSB first) to an LCD character writer over valid/ready.
module display_sink_module #(
  parameter int unsigned LINE_POS  = 0,
  parameter bit          UPPERCASE = 1'b1,
  parameter bit          REFRESH   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        show_input,
  output logic [7:0]  char_out,
  output logic [4:0]  char_pos,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        busy,
  output logic [15:0] shown_value,
  output logic [7:0]  frame_count
);

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned POS_W   = 5;
  localparam int unsigned DIGIT_W = 2;
  localparam int unsigned CNT_W   = 8;

  localparam logic [POS_W-1:0]   BASE_POS   = POS_W'(LINE_POS % 32);
  localparam logic [CHAR_W-1:0]  BLANK_CHAR = 8'h20;
  localparam logic [DIGIT_W-1:0] LAST_DIGIT = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DIGIT_W-1:0]  digit_q, digit_d;
  logic                show_prev_q;
  logic [CHAR_W-1:0]   char_out_d;
  logic [POS_W-1:0]    char_pos_d;
  logic                char_valid_d;
  logic                busy_d;
  logic [DATA_W-1:0]   shown_value_d;
  logic [CNT_W-1:0]    frame_count_d;
  logic                capture_c;
  logic                xfer_c;

  // Map one nibble to its ASCII hex character.
  function automatic logic [CHAR_W-1:0] nibble_to_ascii(input logic [3:0] nib);
    logic [CHAR_W-1:0] ch;
    if (nib < 4'd10) begin
      ch = 8'h30 + CHAR_W'(nib);
    end else if (UPPERCASE) begin
      ch = 8'h37 + CHAR_W'(nib);
    end else begin
      ch = 8'h57 + CHAR_W'(nib);
    end
    return ch;
  endfunction

  // Select digit idx of a value, digit 0 being the most significant nibble.
  function automatic logic [3:0] nibble_sel(input logic [DATA_W-1:0] value,
                                            input logic [DIGIT_W-1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = value[15:12];
      2'd1:    nib = value[11:8];
      2'd2:    nib = value[7:4];
      default: nib = value[3:0];
    endcase
    return nib;
  endfunction

  // New frame on a rising show_input, or on changed data while held high.
  assign capture_c = (show_input && !show_prev_q) ||
                     (REFRESH && show_input && (data_in != shown_value));
  assign xfer_c    = char_valid && char_ready;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      digit_q     <= '0;
      show_prev_q <= 1'b0;
      char_out    <= BLANK_CHAR;
      char_pos    <= '0;
      char_valid  <= 1'b0;
      busy        <= 1'b0;
      shown_value <= '0;
      frame_count <= '0;
    end else begin
      state_q     <= state_d;
      digit_q     <= digit_d;
      show_prev_q <= show_input;
      char_out    <= char_out_d;
      char_pos    <= char_pos_d;
      char_valid  <= char_valid_d;
      busy        <= busy_d;
      shown_value <= shown_value_d;
      frame_count <= frame_count_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    digit_d       = digit_q;
    char_out_d    = char_out;
    char_pos_d    = char_pos;
    char_valid_d  = char_valid;
    busy_d        = busy;
    shown_value_d = shown_value;
    frame_count_d = frame_count;

    case (state_q)
      ST_IDLE: begin
        if (capture_c) begin
          state_d       = ST_SEND;
          shown_value_d = data_in;
          digit_d       = '0;
          char_valid_d  = 1'b1;
          busy_d        = 1'b1;
          char_out_d    = nibble_to_ascii(data_in[15:12]);
          char_pos_d    = BASE_POS;
        end
      end
      ST_SEND: begin
        if (xfer_c) begin
          if (digit_q == LAST_DIGIT) begin
            state_d       = ST_IDLE;
            char_valid_d  = 1'b0;
            busy_d        = 1'b0;
            frame_count_d = frame_count + CNT_W'(1);
          end else begin
            // Later digits come from the captured value, never from live data_in.
            digit_d    = digit_q + DIGIT_W'(1);
            char_out_d = nibble_to_ascii(nibble_sel(shown_value, digit_q + DIGIT_W'(1)));
            char_pos_d = char_pos + POS_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
